// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack port and the decode-side valid/ready port.
// The master side is the fetch unit; the slave side is memory plus decode/control.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        branch;
   logic        br_taken;
   logic        jump;
   logic [31:0] retired;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4, retired,
      input  imem_ack, imem_rdata, instr_ready, branch, br_taken, jump
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4, retired,
      output imem_ack, imem_rdata, instr_ready, branch, br_taken, jump
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per req/ack, hands it to decode under
// valid/ready, and redirects the PC from the consumed instruction's branch/jump outcome.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic        req, valid;
   logic [31:0] pc_plus4, br_offset, next_pc;

   assign pc_plus4  = pc_q + 32'd4;
   assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Jump outranks branch; the condition is only meaningful when branch is set.
   always_comb begin
      if (bus.jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (bus.branch && bus.br_taken) begin
         next_pc = pc_plus4 + br_offset;
      end else begin
         next_pc = pc_plus4;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      req       = 1'b0;
      valid     = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            req = 1'b1;
            if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               state_d = VALID;
            end
         end
         VALID: begin
            valid = 1'b1;
            if (bus.instr_ready) begin
               pc_d      = next_pc;
               retired_d = retired_q + 32'd1;
               state_d   = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= PC_INIT;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_ret = '0;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus2 ();

   instr_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   instr_fetch_unit #(.RESET_PC(32'h8000_0003)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   // Stimulus only: return a word with the given number of wait cycles before ack.
   task automatic serve(input logic [31:0] data, input int waits);
      for (int w = 0; w < waits; w++) begin
         bus.imem_ack = 1'b0;
         @(negedge clk);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = data;
      @(negedge clk);
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'hBAD0_BAD0;
   endtask

   // Stimulus only: consume the current instruction with the given control outcome.
   task automatic consume(input logic j, input logic b, input logic t);
      bus.instr_ready = 1'b1; bus.jump = j; bus.branch = b; bus.br_taken = t;
      @(negedge clk);
      bus.instr_ready = 1'b0; bus.jump = 1'b0; bus.branch = 1'b0; bus.br_taken = 1'b0;
      exp_ret++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
      n_cmp++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
      n_cmp++; if (bus.opcode !== 6'h0) begin n_fail++; $display("FAIL rst_opcode: got %h want 0", bus.opcode); end
      n_cmp++; if (bus.retired !== 32'h0) begin n_fail++; $display("FAIL rst_retired: got %h want 0", bus.retired); end
      n_cmp++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL rst_pc: got %h want 00000040", bus.pc); end
      n_cmp++; if (bus.pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL rst_pc4: got %h want 00000044", bus.pc_plus4); end
      n_cmp++; if (bus2.pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc_align: got %h want 80000000", bus2.pc); end
      rst_n = 1'b1;
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.imem_addr !== 32'h40 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.imem_addr, 32'h40 + 32'(4 * i)); end
         serve(32'h2000_0000 | 32'(i), 0);
         n_cmp++; if ({bus.instr_valid, bus.imem_req} !== 2'b10) begin n_fail++; $display("FAIL seq_vr%0d: got %b want 10", i, {bus.instr_valid, bus.imem_req}); end
         n_cmp++; if (bus.instr !== (32'h2000_0000 | 32'(i))) begin n_fail++; $display("FAIL seq_instr%0d: got %h", i, bus.instr); end
         consume(1'b0, 1'b0, 1'b0);
      end
      n_cmp++; if (bus.retired !== 32'd3) begin n_fail++; $display("FAIL seq_retired: got %0d want 3", bus.retired); end
      n_cmp++; if (bus.imem_addr !== 32'h4C) begin n_fail++; $display("FAIL seq_addr3: got %h want 0000004c", bus.imem_addr); end
   endtask

   task automatic test_wait_states();
      serve(32'h0800_0000, 0);
      consume(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if ({bus.imem_req, bus.instr_valid, bus.imem_addr} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL wait_c%0d: got req=%b valid=%b addr=%h want 1 0 0", c, bus.imem_req, bus.instr_valid, bus.imem_addr); end
         if (c < 3) begin
            bus.imem_ack = 1'b0; bus.imem_rdata = 32'h2400_1234;
            @(negedge clk);
         end else begin
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2400_1234;
            @(negedge clk);
            bus.imem_ack = 1'b0; bus.imem_rdata = 32'hFFFF_FFFF;
         end
      end
      n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: got %b want 1", bus.instr_valid); end
      n_cmp++; if (bus.opcode !== 6'h09) begin n_fail++; $display("FAIL wait_opcode: got %h want 09", bus.opcode); end
      @(negedge clk);
      n_cmp++; if (bus.instr !== 32'h2400_1234) begin n_fail++; $display("FAIL wait_instr: got %h want 24001234", bus.instr); end
      n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wait_pc: got %h want 0", bus.pc); end
   endtask

   task automatic test_branch();
      consume(1'b0, 1'b1, 1'b0);
      n_cmp++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL nt0_addr: got %h want 00000004", bus.imem_addr); end
      serve(32'h0800_0040, 0); consume(1'b1, 1'b0, 1'b0);
      n_cmp++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL jmp_addr: got %h want 00000100", bus.imem_addr); end
      serve(32'h1000_FFFE, 0); consume(1'b0, 1'b1, 1'b1);
      n_cmp++; if (bus.imem_addr !== 32'hFC) begin n_fail++; $display("FAIL br_back: got %h want 000000fc", bus.imem_addr); end
      serve(32'h1000_0000, 0); consume(1'b0, 1'b1, 1'b1);
      n_cmp++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_zero: got %h want 00000100", bus.imem_addr); end
      serve(32'h1000_FFFE, 0); consume(1'b0, 1'b1, 1'b0);
      n_cmp++; if (bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL br_nt: got %h want 00000104", bus.imem_addr); end
      serve(32'h1000_FFFE, 0); consume(1'b0, 1'b0, 1'b1);
      n_cmp++; if (bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL br_unqual: got %h want 00000108", bus.imem_addr); end
   endtask

   task automatic test_stall();
      serve(32'hDEAD_BEEF, 0);
      for (int c = 0; c < 5; c++) begin
         bus.jump = 1'b1; bus.branch = 1'b1; bus.br_taken = 1'b1;
         bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0;
         @(negedge clk);
         n_cmp++; if ({bus.instr, bus.pc, bus.opcode} !== {32'hDEAD_BEEF, 32'h108, 6'h37}) begin n_fail++; $display("FAIL stall_hold%0d: got instr=%h pc=%h op=%h", c, bus.instr, bus.pc, bus.opcode); end
         n_cmp++; if ({bus.imem_req, bus.instr_valid, bus.retired} !== {2'b01, exp_ret}) begin n_fail++; $display("FAIL stall_ctl%0d: got req=%b valid=%b ret=%0d want 0 1 %0d", c, bus.imem_req, bus.instr_valid, bus.retired, exp_ret); end
      end
      bus.jump = 1'b0; bus.branch = 1'b0; bus.br_taken = 1'b0; bus.imem_ack = 1'b0;
      consume(1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.imem_addr !== 32'h10C) begin n_fail++; $display("FAIL stall_adv: got %h want 0000010c", bus.imem_addr); end
      n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL stall_ret: got %0d want %0d", bus.retired, exp_ret); end
   endtask

   task automatic test_reset_mid_fetch();
      n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", bus.imem_req); end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.instr_valid, bus.imem_req, bus.instr, bus.pc, bus.retired} !== {2'b00, 32'h0, 32'h40, 32'h0}) begin n_fail++; $display("FAIL mid_async: got v=%b r=%b instr=%h pc=%h ret=%0d", bus.instr_valid, bus.imem_req, bus.instr, bus.pc, bus.retired); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr} !== {2'b10, 32'h40, 32'h0}) begin n_fail++; $display("FAIL mid_restart: got req=%b v=%b addr=%h instr=%h", bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr); end
      bus.imem_ack = 1'b0;
      @(negedge clk);
      serve(32'hAABB_CCDD, 0);
      n_cmp++; if ({bus.instr_valid, bus.instr} !== {1'b1, 32'hAABB_CCDD}) begin n_fail++; $display("FAIL mid_refetch: got v=%b instr=%h", bus.instr_valid, bus.instr); end
   endtask

   task automatic test_jump_priority();
      n_cmp++; if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'h8000_0000}) begin n_fail++; $display("FAIL jp_fetch: got req=%b addr=%h", bus2.imem_req, bus2.imem_addr); end
      bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0C00_0010;
      @(negedge clk);
      bus2.imem_ack = 1'b0;
      n_cmp++; if ({bus2.instr_valid, bus2.opcode} !== {1'b1, 6'h03}) begin n_fail++; $display("FAIL jp_valid: got v=%b op=%h", bus2.instr_valid, bus2.opcode); end
      bus2.instr_ready = 1'b1; bus2.jump = 1'b1; bus2.branch = 1'b1; bus2.br_taken = 1'b1;
      @(negedge clk);
      bus2.instr_ready = 1'b0; bus2.jump = 1'b0; bus2.branch = 1'b0; bus2.br_taken = 1'b0;
      n_cmp++; if (bus2.imem_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL jp_addr: got %h want 80000040", bus2.imem_addr); end
      n_cmp++; if (bus2.retired !== 32'd1) begin n_fail++; $display("FAIL jp_ret: got %0d want 1", bus2.retired); end
   endtask

   initial begin
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
      bus.branch = 1'b0; bus.br_taken = 1'b0; bus.jump = 1'b0;
      bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b0;
      bus2.branch = 1'b0; bus2.br_taken = 1'b0; bus2.jump = 1'b0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch();
      test_stall();
      test_jump_priority();
      test_reset_mid_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-cycle datapath. Holds the program counter and requests instruction words from instruction memory over a req/ack handshake. Presents the fetched word, with its opcode field split out for the control unit, to the decode/execute side under a valid/ready handshake. Computes the next PC (sequential, branch, jump) from the consumed instruction plus the branch/jump/condition signals returned by control unit and ALU.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch; bits [1:0] forced to 0 internally.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  byte address of requested word (= pc)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- instr_valid  out  1  instr/pc outputs hold a fetched instruction
- instr_ready  in  1  downstream consumes the instruction this cycle
- instr  out  32  fetched instruction register
- opcode  out  6  instr[31:26], feeds control unit opcode input
- pc  out  32  address of instr
- pc_plus4  out  32  pc + 4
- branch  in  1  control-unit branch for current instr
- br_taken  in  1  branch condition met (ALU result), qualified by branch
- jump  in  1  control-unit jump for current instr
- retired  out  32  count of consumed instructions

## Operation
- FSM states: IDLE, FETCH, VALID.
- IDLE: entered on reset; imem_req=0; next edge -> FETCH.
- FETCH: imem_req=1, imem_addr=pc held stable. On edge with imem_ack=1: instr <= imem_rdata, -> VALID. No ack: stay.
- VALID: instr_valid=1, imem_req=0. On edge with instr_ready=1: pc <= next_pc, retired <= retired+1, -> FETCH. No ready: stay, all outputs frozen.
- next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch & br_taken -> pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4.
- branch, br_taken, jump sampled only on the consuming edge; ignored elsewhere.
- All PC arithmetic modulo 2^32 (wraps at 32'hFFFF_FFFC -> 0). pc[1:0] always 00.
- retired wraps from 32'hFFFF_FFFF to 0.
- imem_ack outside FETCH ignored; imem_rdata outside ack ignored.
- opcode and pc_plus4 combinational from instr/pc registers.

## Timing
- Reset values: state IDLE, pc=RESET_PC&~3, instr=0, retired=0, imem_req=0, instr_valid=0, opcode=0, pc_plus4=pc+4.
- rst_n low at any time: immediate return to reset values; an outstanding fetch is abandoned, an ack in the same or following cycle is ignored.
- First imem_req rises one cycle after rst_n deassert edge (IDLE -> FETCH).
- Fetch latency: ack in first FETCH cycle -> instr_valid next cycle. Each extra wait cycle adds one.
- Peak throughput: one instruction per 2 cycles (FETCH 1, VALID 1) with ack and ready both immediate.
- imem_req and instr_valid never high together.
- Redirected PC appears on imem_addr the cycle after the consuming edge; no wrong-path fetch issued.
- jump and branch both high: jump wins.

## Test plan
- Reset, RESET_PC=32'h0000_0040, ack immediate, ready high: imem_addr sequence 40,44,48; retired=3 after third consume; imem_req first high one cycle after reset release.
- Memory delays ack 3 cycles at pc=0: imem_addr stable at 0 for 4 FETCH cycles, instr_valid rises the cycle after ack, instr=imem_rdata sampled at ack edge.
- instr=32'h1000_FFFE at pc=0x100 with branch=1, br_taken=1: next imem_addr=0x0FC; with br_taken=0: 0x104.
- instr=32'h0C00_0010 at pc=0x8000_0000 with jump=1, branch=1: next imem_addr=0x8000_0040.
- Hold instr_ready low 5 cycles in VALID: instr, pc, opcode unchanged, imem_req=0, retired unchanged; then ready -> advance once.
- Assert rst_n low mid-FETCH with ack arriving same cycle: pc=RESET_PC, instr=0, instr_valid=0 after reset; fetch restarts at RESET_PC.
